// File: rtl/seg_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter driving active-low 7-segment digits.
// Optional feature macro: SEG_LZ_BLANK_EN (leading-zero blanking).
module seg_bcd_display #(
  parameter int IN_W   = 7,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  KEY0,
  input  logic [IN_W-1:0]       bin_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   seg_out
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CONV  = 2'd2
  } state_t;

  function automatic logic [31:0] max_display(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Largest value that fits in DIGITS decimal digits; 32 bits covers IN_W+1 for IN_W<=20.
  localparam logic [31:0] MAX_VAL = max_display(DIGITS);

  state_t                r_state;
  state_t                w_state_next;
  logic [IN_W-1:0]       r_bin;
  logic [BCD_W-1:0]      r_bcd;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf_next;
  logic                  r_ovf;
  logic                  r_busy;
  logic                  r_done;
  logic [7*DIGITS-1:0]   r_seg;

  logic                  w_ovf_in;
  logic                  w_last_shift;
  logic [BCD_W-1:0]      w_bcd_adj;
  logic [7*DIGITS-1:0]   w_seg_next;
  logic [3:0]            w_nib;
  logic                  w_shown;

  assign w_ovf_in     = ({{(32-IN_W){1'b0}}, bin_in} > MAX_VAL);
  assign w_last_shift = (r_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_next = S_SHIFT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last_shift) begin
          w_state_next = S_CONV;
        end else begin
          w_state_next = S_SHIFT;
        end
      end
      S_CONV:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end else begin
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4];
      end
    end
  end

  // Segment image for the finished BCD value, scanned from the top digit down
  always_comb begin
    w_seg_next = {(7*DIGITS){1'b1}};
    w_nib      = 4'd0;
    w_shown    = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_nib = r_bcd[4*k +: 4];
`ifdef SEG_LZ_BLANK_EN
      if ((w_nib != 4'd0) || (k == 0)) begin
        w_shown = 1'b1;
      end else begin
        w_shown = w_shown;
      end
`else
      w_shown = 1'b1;
`endif
      if (r_ovf_next) begin
        w_seg_next[7*k +: 7] = SEG_DASH;
      end else if (w_shown) begin
        w_seg_next[7*k +: 7] = seg_encode(w_nib);
      end else begin
        w_seg_next[7*k +: 7] = SEG_BLANK;
      end
    end
  end

  // Datapath and registered outputs; seg_out only changes in CONV so it never flickers
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_next <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_seg      <= {(7*DIGITS){1'b1}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin      <= bin_in;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(IN_W);
            r_ovf_next <= w_ovf_in;
            r_busy     <= 1'b1;
          end else begin
            r_busy     <= 1'b0;
          end
        end
        S_SHIFT: begin
          // The carry out of the top nibble falls off the end here
          {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
          r_cnt          <= r_cnt - CNT_W'(1);
        end
        S_CONV: begin
          r_seg  <= w_seg_next;
          r_ovf  <= r_ovf_next;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign ovf     = r_ovf;
  assign seg_out = r_seg;

endmodule

// File: tb/tb_seg_bcd_display.sv
// Scoreboard bench: stimulus pushes expected {ovf,seg_out}; per-DUT monitors pop on done.
module tb_seg_bcd_display;

  logic        clk;
  logic        key0;
  logic [6:0]  bin_a;
  logic        load_a;
  logic        busy_a, done_a, ovf_a;
  logic [20:0] seg_a;
  logic [9:0]  bin_b;
  logic        load_b;
  logic        busy_b, done_b, ovf_b;
  logic [20:0] seg_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [21:0] q_a[$];
  logic [21:0] q_b[$];

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SD = 7'b1111110;
`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b0000001;
`endif

  seg_bcd_display #(.IN_W(7), .DIGITS(3)) dut_a (
    .CLOCK_50(clk), .KEY0(key0), .bin_in(bin_a), .load(load_a),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .seg_out(seg_a)
  );

  seg_bcd_display #(.IN_W(10), .DIGITS(3)) dut_b (
    .CLOCK_50(clk), .KEY0(key0), .bin_in(bin_b), .load(load_b),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .seg_out(seg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the IN_W=7 instance
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("unexpected_done_a", 32'd1, 32'd0);
      end else begin
        chk("result_a", {10'd0, ovf_a, seg_a}, {10'd0, q_a.pop_front()});
      end
    end
  end

  // Monitor for the IN_W=10 instance
  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("unexpected_done_b", 32'd1, 32'd0);
      end else begin
        chk("result_b", {10'd0, ovf_b, seg_b}, {10'd0, q_b.pop_front()});
      end
    end
  end

  task automatic wait_idle_a();
    int n = 0;
    @(negedge clk);
    while (busy_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_a", {31'd0, busy_a}, 32'd0);
  endtask

  task automatic issue_a(input logic [6:0] v, input logic [21:0] exp);
    wait_idle_a();
    bin_a  = v;
    load_a = 1'b1;
    q_a.push_back(exp);
    @(posedge clk);
    #1 load_a = 1'b0;
  endtask

  task automatic issue_b(input logic [9:0] v, input logic [21:0] exp);
    int n = 0;
    @(negedge clk);
    while (busy_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_b", {31'd0, busy_b}, 32'd0);
    bin_b  = v;
    load_b = 1'b1;
    q_b.push_back(exp);
    @(posedge clk);
    #1 load_b = 1'b0;
  endtask

  initial begin
    int bc;
    int seen;
    int n;
    key0   = 1'b0;
    load_a = 1'b1;
    bin_a  = 7'd5;
    load_b = 1'b1;
    bin_b  = 10'd5;
    repeat (2) @(posedge clk);
    #1;
    key0   = 1'b1;
    load_a = 1'b0;
    load_b = 1'b0;
    @(negedge clk);
    chk("rst_seg_a",  {11'd0, seg_a}, 32'h1FFFFF);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_done_a", {31'd0, done_a}, 32'd0);
    chk("rst_ovf_a",  {31'd0, ovf_a}, 32'd0);
    chk("rst_seg_b",  {11'd0, seg_b}, 32'h1FFFFF);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);

    // 127: busy for 8 cycles, done after the 9th edge
    issue_a(7'd127, {1'b0, S1, S2, S7});
    bc = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) begin
        seen = 1;
        break;
      end
      if (busy_a) bc++;
    end
    chk("busy_cycles", bc, 32'd8);
    chk("done_seen", seen, 32'd1);

    issue_a(7'd5, {1'b0, LZ, LZ, S5});
    issue_a(7'd0, {1'b0, LZ, LZ, S0});

    issue_b(10'd1000, {1'b1, SD, SD, SD});
    issue_b(10'd999,  {1'b0, S9, S9, S9});
    issue_b(10'd1023, {1'b1, SD, SD, SD});

    // Load held through busy is ignored, then accepted on the done cycle
    issue_a(7'd42, {1'b0, LZ, S4, S2});
    @(posedge clk);
    #1;
    bin_a  = 7'd99;
    load_a = 1'b1;
    q_a.push_back({1'b0, LZ, S9, S9});
    n = 0;
    @(negedge clk);
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_42", {31'd0, done_a}, 32'd1);
    @(posedge clk);
    #1 load_a = 1'b0;
    @(negedge clk);
    chk("reload_busy", {31'd0, busy_a}, 32'd1);

    // Reset mid-SHIFT aborts without a done pulse
    wait_idle_a();
    bin_a  = 7'd77;
    load_a = 1'b1;
    @(posedge clk);
    #1 load_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 key0 = 1'b0;
    @(posedge clk);
    #1 key0 = 1'b1;
    @(negedge clk);
    chk("abort_seg",  {11'd0, seg_a}, 32'h1FFFFF);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_done", {31'd0, done_a}, 32'd0);
    repeat (12) @(negedge clk);
    issue_a(7'd100, {1'b0, S1, S0, S0});

    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_a", q_a.size(), 32'd0);
    chk("drain_b", q_b.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
